// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin sequencer sharing one
// combinational multiplier among N requesting cores.
module mul_arbiter #(
  parameter  int N   = 4,
  parameter  int W   = 8,
  localparam int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] a_in,
  input  logic [N*W-1:0] b_in,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic [N-1:0]   done,
  output logic [W-1:0]   result,
  output logic           busy,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic [W-1:0]   mul_result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [IDW-1:0] r_last;
  logic [IDW-1:0] w_last_nxt;
  logic [N-1:0]   r_gnt;
  logic [N-1:0]   w_gnt_nxt;
  logic [N-1:0]   r_done;
  logic [N-1:0]   w_done_nxt;
  logic [IDW-1:0] r_gnt_id;
  logic [IDW-1:0] w_id_nxt;
  logic [W-1:0]   r_result;
  logic [W-1:0]   w_res_nxt;
  logic [W-1:0]   r_mul_a;
  logic [W-1:0]   w_a_nxt;
  logic [W-1:0]   r_mul_b;
  logic [W-1:0]   w_b_nxt;

  logic           w_found;
  logic [IDW-1:0] w_win;
  logic [IDW-1:0] w_cand;
  int             w_idx;

  // Round-robin search starting just after the last served core
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    w_idx   = 0;
    for (int k = 1; k <= N; k++) begin
      w_idx  = (int'(r_last) + k) % N;
      w_cand = IDW'(w_idx);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  // Next-state and next-register values
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = '0;
    w_done_nxt  = '0;
    w_id_nxt    = r_gnt_id;
    w_last_nxt  = r_last;
    w_res_nxt   = r_result;
    w_a_nxt     = r_mul_a;
    w_b_nxt     = r_mul_b;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_gnt_nxt   = N'(1) << w_win;
          w_id_nxt    = w_win;
          w_a_nxt     = a_in[w_win*W +: W];
          w_b_nxt     = b_in[w_win*W +: W];
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        w_res_nxt   = mul_result;
        w_done_nxt  = N'(1) << r_gnt_id;
        w_state_nxt = DONE;
      end
      DONE: begin
        w_last_nxt  = r_gnt_id;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers; last starts at N-1 so core 0 leads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_last   <= IDW'(N - 1);
      r_gnt    <= '0;
      r_done   <= '0;
      r_gnt_id <= '0;
      r_result <= '0;
      r_mul_a  <= '0;
      r_mul_b  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_last   <= w_last_nxt;
      r_gnt    <= w_gnt_nxt;
      r_done   <= w_done_nxt;
      r_gnt_id <= w_id_nxt;
      r_result <= w_res_nxt;
      r_mul_a  <= w_a_nxt;
      r_mul_b  <= w_b_nxt;
    end
  end

  assign gnt    = r_gnt;
  assign done   = r_done;
  assign gnt_id = r_gnt_id;
  assign result = r_result;
  assign mul_a  = r_mul_a;
  assign mul_b  = r_mul_b;
  assign busy   = (r_state != IDLE);

endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: scoreboard bench for the shared
// multiplier arbiter, with a behavioural MUL.
module tb_mul_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_in;
  logic [N*W-1:0] b_in;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic [N-1:0]   done;
  logic [W-1:0]   result;
  logic           busy;
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_b;
  logic [W-1:0]   mul_result;

  typedef struct {
    logic [IDW-1:0] id;
    logic [W-1:0]   res;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  // The external combinational multiplier
  assign mul_result = mul_a * mul_b;

  mul_arbiter #(.N(N), .W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .a_in       (a_in),
    .b_in       (b_in),
    .gnt        (gnt),
    .gnt_id     (gnt_id),
    .done       (done),
    .result     (result),
    .busy       (busy),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result)
  );

  task automatic drive_req(
    input logic [IDW-1:0] id,
    input logic [W-1:0]   a,
    input logic [W-1:0]   b,
    input logic [W-1:0]   prod
  );
    exp_t e;
    req[id]         = 1'b1;
    a_in[id*W +: W] = a;
    b_in[id*W +: W] = b;
    e.id  = id;
    e.res = prod;
    exp_q.push_back(e);
  endtask

  // Bounded wait for a done pulse; d stays 0 on timeout
  task automatic wait_done(
    output logic [N-1:0] d,
    output int           cyc
  );
    d   = '0;
    cyc = 0;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (done != '0) begin
        d = done;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = '0;
    a_in  = '0;
    b_in  = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({gnt, done, gnt_id, result, mul_a, mul_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_outs got %h/%h/%h/%h/%h/%h want 0",
               gnt, done, gnt_id, result, mul_a, mul_b);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy got %b want 0", busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || gnt !== '0) begin
      n_fail++;
      $display("FAIL idle_after_reset busy %b gnt %b want 0",
               busy, gnt);
    end
  endtask

  task automatic test_single();
    logic [N-1:0] d;
    int           cyc;
    exp_t         e;
    drive_req(2'd0, 8'd3, 8'd4, 8'd12);
    @(negedge clk);
    n_checks++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_gnt got %b id %0d busy %b want 0001 0 1",
               gnt, gnt_id, busy);
    end
    n_checks++;
    if (mul_a !== 8'd3 || mul_b !== 8'd4) begin
      n_fail++;
      $display("FAIL single_ops got %0d,%0d want 3,4", mul_a, mul_b);
    end
    wait_done(d, cyc);
    e = exp_q.pop_front();
    n_checks++;
    if (d !== (N'(1) << e.id) || cyc !== 1) begin
      n_fail++;
      $display("FAIL single_done got %b after %0d want %b after 1",
               d, cyc, N'(1) << e.id);
    end
    n_checks++;
    if (result !== e.res || gnt !== '0) begin
      n_fail++;
      $display("FAIL single_result got %0d gnt %b want %0d gnt 0",
               result, gnt, e.res);
    end
    req = '0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== '0) begin
      n_fail++;
      $display("FAIL single_end busy %b done %b want 0 0", busy, done);
    end
    n_checks++;
    if (mul_a !== 8'd3 || mul_b !== 8'd4 || result !== 8'd12) begin
      n_fail++;
      $display("FAIL hold got %0d,%0d,%0d want 3,4,12",
               mul_a, mul_b, result);
    end
  endtask

  task automatic test_sequential();
    logic [IDW-1:0] ids[2] = '{2'd2, 2'd1};
    logic [W-1:0]   as[2]  = '{8'd15, 8'd10};
    logic [W-1:0]   bs[2]  = '{8'd2, 8'd10};
    logic [W-1:0]   ps[2]  = '{8'd30, 8'd100};
    logic [N-1:0]   d;
    int             cyc;
    exp_t           e;
    for (int i = 0; i < 2; i++) begin
      drive_req(ids[i], as[i], bs[i], ps[i]);
      wait_done(d, cyc);
      e = exp_q.pop_front();
      n_checks++;
      if (d !== (N'(1) << e.id) || gnt_id !== e.id) begin
        n_fail++;
        $display("FAIL seq_done[%0d] got %b id %0d want %b id %0d",
                 i, d, gnt_id, N'(1) << e.id, e.id);
      end
      n_checks++;
      if (result !== e.res || cyc !== 2) begin
        n_fail++;
        $display("FAIL seq_result[%0d] got %0d after %0d want %0d after 2",
                 i, result, cyc, e.res);
      end
      req = '0;
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    logic [IDW-1:0] ids[2] = '{2'd0, 2'd3};
    logic [W-1:0]   as[2]  = '{8'd16, 8'd255};
    logic [W-1:0]   ps[2]  = '{8'd0, 8'd1};
    logic [N-1:0]   d;
    int             cyc;
    exp_t           e;
    for (int i = 0; i < 2; i++) begin
      drive_req(ids[i], as[i], as[i], ps[i]);
      wait_done(d, cyc);
      e = exp_q.pop_front();
      n_checks++;
      if (d !== (N'(1) << e.id) || result !== e.res) begin
        n_fail++;
        $display("FAIL wrap[%0d] got %b/%0d want %b/%0d",
                 i, d, result, N'(1) << e.id, e.res);
      end
      req = '0;
      @(negedge clk);
    end
  endtask

  task automatic test_fairness();
    logic [N-1:0] d;
    int           cyc;
    exp_t         e;
    for (int i = 0; i < N; i++) begin
      drive_req(IDW'(i), W'(i + 1), 8'd2, W'(2 * (i + 1)));
    end
    e.id  = 2'd0;
    e.res = 8'd2;
    exp_q.push_back(e);
    for (int k = 0; k < 5; k++) begin
      wait_done(d, cyc);
      e = exp_q.pop_front();
      n_checks++;
      if (d !== (N'(1) << e.id) || result !== e.res) begin
        n_fail++;
        $display("FAIL fair[%0d] got %b/%0d want %b/%0d",
                 k, d, result, N'(1) << e.id, e.res);
      end
      n_checks++;
      if (cyc !== ((k == 0) ? 2 : 3) || gnt !== '0) begin
        n_fail++;
        $display("FAIL fair_gap[%0d] got %0d gnt %b want %0d gnt 0",
                 k, cyc, gnt, (k == 0) ? 2 : 3);
      end
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_priority();
    logic [N-1:0] d;
    int           cyc;
    exp_t         e;
    drive_req(2'd3, 8'd5, 8'd5, 8'd25);
    wait_done(d, cyc);
    e = exp_q.pop_front();
    n_checks++;
    if (d !== 4'b1000 || result !== e.res) begin
      n_fail++;
      $display("FAIL prio_pre got %b/%0d want 1000/%0d",
               d, result, e.res);
    end
    req = '0;
    @(negedge clk);
    drive_req(2'd0, 8'd7, 8'd3, 8'd21);
    drive_req(2'd3, 8'd9, 8'd9, 8'd81);
    for (int k = 0; k < 2; k++) begin
      wait_done(d, cyc);
      e = exp_q.pop_front();
      n_checks++;
      if (d !== (N'(1) << e.id) || result !== e.res) begin
        n_fail++;
        $display("FAIL prio[%0d] got %b/%0d want %b/%0d",
                 k, d, result, N'(1) << e.id, e.res);
      end
      req[e.id] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] d;
    logic [N-1:0] seen;
    int           cyc;
    exp_t         e;
    req[0]      = 1'b1;
    a_in[7:0]   = 8'd6;
    b_in[7:0]   = 8'd7;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    req   = '0;
    #1;
    n_checks++;
    if ({gnt, done, gnt_id, result, mul_a, mul_b, busy} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset got %b/%b/%0d/%0d/%0d/%0d/%b want 0",
               gnt, done, gnt_id, result, mul_a, mul_b, busy);
    end
    seen = '0;
    repeat (2) begin
      @(negedge clk);
      seen = seen | done;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      seen = seen | done;
    end
    n_checks++;
    if (seen !== '0 || result !== '0) begin
      n_fail++;
      $display("FAIL mid_nodone got %b result %0d want 0 0",
               seen, result);
    end
    drive_req(2'd0, 8'd6, 8'd7, 8'd42);
    wait_done(d, cyc);
    e = exp_q.pop_front();
    n_checks++;
    if (d !== 4'b0001 || result !== e.res || cyc !== 2) begin
      n_fail++;
      $display("FAIL mid_after got %b/%0d/%0d want 0001/%0d/2",
               d, result, cyc, e.res);
    end
    req = '0;
    @(negedge clk);
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL queue_left got %0d want 0", exp_q.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_sequential();
    test_wrap();
    test_fairness();
    test_priority();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
